arithmetic_unit: RTL and testbench

Parametrised, handshaked integer execute unit, successor to the combinational ALU. Accepts one RV32I register/immediate arithmetic operation or, when enabled, one RV32M multiply/divide operation per handshake. Returns a registered result plus an illegal-code flag. Sits between operand read/immediate decode and writeback. Single-cycle operations sustain one result per clock; division is iterative.

---
 rtl/arithmetic_unit.sv | 140 ++++++++++++++
 tb/tb_arithmetic_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arithmetic_unit.sv
// arithmetic_unit: handshaked RV32I/RV32M execute unit with iterative restoring divider
module arithmetic_unit #(
    parameter int DATA_WIDTH = 32,
    parameter bit ENABLE_M   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] lhs,
    input  logic [DATA_WIDTH-1:0] rhs,
    input  logic [14:12]          operation,
    input  logic [31:25]          metadata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  illegal,
    output logic                  busy
);
    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(W);

    typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

    state_t          state, state_nx;
    logic            accept, m_op, base_ok, legal, is_div, div_sgn;
    logic            lhs_neg, rhs_neg, div_zero, div_ovf, div_norm, last;
    logic [W-1:0]    lhs_mag, rhs_mag, alu_res, sra_res, mul_res, spec_res, load_res;
    logic [SW-1:0]   shamt, count;
    logic [2*W-1:0]  ma, mb, prod;
    logic [W-1:0]    q_reg, r_reg, d_reg, q_nx, r_nx, div_res;
    logic            neg_q, neg_r, rem_sel;
    logic [W:0]      rem_shift, diff;

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign out_valid = state == DONE;
    assign busy      = state == DIVIDE;
    assign accept    = in_valid && in_ready;

    assign m_op     = ENABLE_M && metadata == 7'h01;
    assign base_ok  = metadata == 7'h00 || (metadata == 7'h20 && (operation == 3'd0 || operation == 3'd5));
    assign legal    = base_ok || m_op;
    assign is_div   = m_op && operation[14];
    assign div_sgn  = !operation[12];
    assign lhs_neg  = div_sgn && lhs[W-1];
    assign rhs_neg  = div_sgn && rhs[W-1];
    assign div_zero = rhs == '0;
    assign div_ovf  = div_sgn && lhs == {1'b1, {(W-1){1'b0}}} && rhs == '1;
    assign div_norm = is_div && !div_zero && !div_ovf;
    assign lhs_mag  = lhs_neg ? -lhs : lhs;
    assign rhs_mag  = rhs_neg ? -rhs : rhs;

    // A 2W-bit modular product of sign/zero-extended operands gives every
    // high-half variant exactly, since each true product fits in 2W bits.
    assign ma      = {{W{lhs[W-1] && operation != 3'd3}}, lhs};
    assign mb      = {{W{rhs[W-1] && operation == 3'd1}}, rhs};
    assign prod    = ma * mb;
    assign mul_res = operation == 3'd0 ? prod[W-1:0] : prod[2*W-1:W];

    // Divide-by-zero and signed overflow finish without iterating.
    assign spec_res = div_zero ? (operation[13] ? lhs : '1) : (operation[13] ? '0 : lhs);

    assign shamt   = rhs[SW-1:0];
    assign sra_res = $signed(lhs) >>> shamt;

    // Base-ISA result, selected by funct3 with funct7 bit 5 picking sub/sra.
    always_comb begin
        alu_res = '0;
        case (operation)
            3'd0: alu_res = metadata[30] ? lhs - rhs : lhs + rhs;
            3'd1: alu_res = lhs << shamt;
            3'd2: alu_res = {{(W-1){1'b0}}, $signed(lhs) < $signed(rhs)};
            3'd3: alu_res = {{(W-1){1'b0}}, lhs < rhs};
            3'd4: alu_res = lhs ^ rhs;
            3'd5: alu_res = metadata[30] ? sra_res : lhs >> shamt;
            3'd6: alu_res = lhs | rhs;
            default: alu_res = lhs & rhs;
        endcase
    end

    assign load_res = !legal ? '0 : m_op ? (operation[14] ? spec_res : mul_res) : alu_res;

    // One restoring step: shift in the next dividend bit, keep the difference if non-negative.
    assign rem_shift = {r_reg, q_reg[W-1]};
    assign diff      = rem_shift - {1'b0, d_reg};
    assign q_nx      = {q_reg[W-2:0], !diff[W]};
    assign r_nx      = diff[W] ? rem_shift[W-1:0] : diff[W-1:0];
    assign div_res   = rem_sel ? (neg_r ? -r_nx : r_nx) : (neg_q ? -q_nx : q_nx);
    assign last      = count == SW'(W - 1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decode: accepts take priority over returning to IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (div_norm ? DIVIDE : DONE) : IDLE;
            DIVIDE:  state_nx = last ? DONE : DIVIDE;
            DONE:    state_nx = accept ? (div_norm ? DIVIDE : DONE) : (out_ready ? IDLE : DONE);
            default: state_nx = IDLE;
        endcase
    end

    // Result/flag capture and divider iteration; sign correction lands with the final step.
    always_ff @(posedge clk) begin
        if (rst) begin
            result  <= '0;
            illegal <= 1'b0;
            q_reg   <= '0;
            r_reg   <= '0;
            d_reg   <= '0;
            count   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            rem_sel <= 1'b0;
        end else if (accept) begin
            illegal <= !legal;
            if (div_norm) begin
                q_reg   <= lhs_mag;
                r_reg   <= '0;
                d_reg   <= rhs_mag;
                count   <= '0;
                neg_q   <= lhs_neg ^ rhs_neg;
                neg_r   <= lhs_neg;
                rem_sel <= operation[13];
            end else begin
                result <= load_res;
            end
        end else if (state == DIVIDE) begin
            q_reg <= q_nx;
            r_reg <= r_nx;
            count <= count + 1'b1;
            if (last) result <= div_res;
        end
    end
endmodule

// File: tb/tb_arithmetic_unit.sv
// tb_arithmetic_unit: directed and stall-stress bench with a scoreboard model
module tb_arithmetic_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b1, nom_valid = 1'b0;
    logic [31:0] lhs = '0, rhs = '0;
    logic [2:0]  operation = '0;
    logic [6:0]  metadata = '0;
    logic        in_ready, out_valid, illegal, busy;
    logic [31:0] result;
    logic        nom_in_ready, nom_out_valid, nom_illegal, nom_busy;
    logic [31:0] nom_result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    arithmetic_unit #(.DATA_WIDTH(32), .ENABLE_M(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .lhs(lhs), .rhs(rhs), .operation(operation), .metadata(metadata),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .illegal(illegal), .busy(busy)
    );

    arithmetic_unit #(.DATA_WIDTH(32), .ENABLE_M(1'b0)) dut_nom (
        .clk(clk), .rst(rst), .in_valid(nom_valid), .in_ready(nom_in_ready),
        .lhs(lhs), .rhs(rhs), .operation(operation), .metadata(metadata),
        .out_valid(nom_out_valid), .out_ready(1'b1), .result(nom_result),
        .illegal(nom_illegal), .busy(nom_busy)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference semantics straight from the ISA rules; lat is cycles from the
    // last pre-accept sample to the first sample showing out_valid.
    function automatic void model(input logic [2:0] op, input logic [6:0] f7,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
        int          sa, sb;
        longint      sp;
        logic [63:0] up;
        sa = a; sb = b; r = '0; ill = 1'b0; lat = 1; sp = 0; up = '0;
        if (f7 == 7'h00) begin
            case (op)
                3'd0: r = a + b;
                3'd1: r = a << b[4:0];
                3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
                3'd3: r = (a < b) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: r = a >> b[4:0];
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end else if (f7 == 7'h20 && op == 3'd0) r = a - b;
        else if (f7 == 7'h20 && op == 3'd5) r = sa >>> b[4:0];
        else if (f7 == 7'h01) begin
            if (op == 3'd0) r = a * b;
            else if (op == 3'd1) begin sp = longint'(sa) * longint'(sb); r = sp[63:32]; end
            else if (op == 3'd2) begin sp = longint'(sa) * longint'({32'b0, b}); r = sp[63:32]; end
            else if (op == 3'd3) begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
            else if (b == 0) r = op[1] ? a : 32'hFFFFFFFF;
            else if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) r = op[1] ? 32'd0 : a;
            else begin
                lat = 33;
                case (op)
                    3'd4: r = sa / sb;
                    3'd5: r = a / b;
                    3'd6: r = sa % sb;
                    default: r = a % b;
                endcase
            end
        end else ill = 1'b1;
    endfunction

    typedef struct { logic [31:0] r; logic ill; int rdy; } exp_t;
    exp_t        sb[$];
    int          cyc = 0;
    logic        held = 1'b0, held_i = 1'b0;
    logic [31:0] held_r = '0;

    // Scoreboard: every cycle, handshake outputs and results against the model.
    always @(negedge clk) begin : scoreboard
        exp_t        e;
        logic        pend, ov;
        logic [31:0] mr;
        logic        mi;
        int          ml;
        cyc++;
        if (rst) begin
            sb.delete();
            held = 1'b0;
        end else begin
            pend = sb.size() != 0;
            ov = 1'b0;
            if (pend) ov = cyc >= sb[0].rdy;
            check("out_valid", out_valid, ov);
            check("in_ready", in_ready, !pend || (ov && out_ready));
            check("busy", busy, pend && !ov);
            if (out_valid && pend) begin
                check("result", result, sb[0].r);
                check("illegal", illegal, sb[0].ill);
            end
            if (held) begin
                check("held_valid", out_valid, 1'b1);
                check("held_result", result, held_r);
                check("held_illegal", illegal, held_i);
            end
            held = out_valid && !out_ready;
            held_r = result;
            held_i = illegal;
            if (out_valid && out_ready && pend) void'(sb.pop_front());
            if (in_valid && in_ready) begin
                model(operation, metadata, lhs, rhs, mr, mi, ml);
                e.r = mr; e.ill = mi; e.rdy = cyc + ml;
                sb.push_back(e);
            end
        end
    end

    task automatic issue(input string nm, input logic [2:0] op, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input logic exp_ill, input int exp_lat);
        logic [31:0] mr;
        logic        mi;
        int          ml, lat, bz;
        bit          acc;
        model(op, f7, a, b, mr, mi, ml);
        check({nm, "_model"}, mr, exp);
        check({nm, "_model_ill"}, mi, exp_ill);
        @(posedge clk); #1;
        operation = op; metadata = f7; lhs = a; rhs = b; in_valid = 1'b1; out_ready = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
        end
        check({nm, "_accepted"}, acc, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0; bz = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            bz += busy;
        end
        check({nm, "_latency"}, lat, exp_lat);
        check({nm, "_busy_cycles"}, bz, exp_lat - 1);
        check({nm, "_result"}, result, exp);
        check({nm, "_illegal"}, illegal, exp_ill);
    endtask

    logic [6:0] f7_pool [4] = '{7'h00, 7'h20, 7'h01, 7'h10};

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_result", result, 32'd0);
        check("reset_illegal", illegal, 1'b0);

        issue("add",     3'd0, 7'h00, 32'd7,        32'd5,        32'd12,       1'b0, 1);
        issue("sub",     3'd0, 7'h20, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1);
        issue("sra",     3'd5, 7'h20, 32'h80000000, 32'h21,       32'hC0000000, 1'b0, 1);
        issue("srl",     3'd5, 7'h00, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1);
        issue("sll",     3'd1, 7'h00, 32'd1,        32'h3F,       32'h80000000, 1'b0, 1);
        issue("xor",     3'd4, 7'h00, 32'hF0F0,     32'h0FF0,     32'hFF00,     1'b0, 1);
        issue("or",      3'd6, 7'h00, 32'hA,        32'h5,        32'hF,        1'b0, 1);
        issue("and",     3'd7, 7'h00, 32'hC,        32'hA,        32'h8,        1'b0, 1);
        issue("slt",     3'd2, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1);
        issue("sltu",    3'd3, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1);
        issue("mul",     3'd0, 7'h01, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD, 1'b0, 1);
        issue("mulh",    3'd1, 7'h01, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1);
        issue("mulhsu",  3'd2, 7'h01, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, 1);
        issue("mulhu",   3'd3, 7'h01, 32'hFFFFFFFF, 32'd2,        32'd1,        1'b0, 1);
        issue("div",     3'd4, 7'h01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 33);
        issue("rem",     3'd6, 7'h01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 33);
        issue("divu",    3'd5, 7'h01, 32'd100,      32'd7,        32'd14,       1'b0, 33);
        issue("remu",    3'd7, 7'h01, 32'd100,      32'd7,        32'd2,        1'b0, 33);
        issue("div_pn",  3'd4, 7'h01, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33);
        issue("rem_pn",  3'd6, 7'h01, 32'd7,        32'hFFFFFFFE, 32'd1,        1'b0, 33);
        issue("div0",    3'd4, 7'h01, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 1);
        issue("rem0",    3'd6, 7'h01, 32'd5,        32'd0,        32'd5,        1'b0, 1);
        issue("div_ovf", 3'd4, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
        issue("rem_ovf", 3'd6, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, 1);
        issue("ill_10",  3'd0, 7'h10, 32'd9,        32'd9,        32'd0,        1'b1, 1);
        issue("ill_sll", 3'd1, 7'h20, 32'd9,        32'd1,        32'd0,        1'b1, 1);

        // Back-to-back single-cycle ops, one per clock.
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            operation = 3'd0; metadata = 7'h00; lhs = 32'(i * 3); rhs = 32'(i); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;

        // Random stalls on both sides with a mix of codes and corner operands.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = $urandom_range(0, 3) != 0;
            operation = 3'($urandom);
            metadata  = f7_pool[$urandom_range(0, 3)];
            lhs = $urandom_range(0, 5) == 0 ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 4))
                0: rhs = 32'd0;
                1: rhs = 32'hFFFFFFFF;
                2: rhs = $urandom_range(1, 9);
                default: rhs = $urandom;
            endcase
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("drained", sb.size(), 0);

        // Reset in the middle of a division discards it.
        operation = 3'd4; metadata = 7'h01; lhs = 32'd1000; rhs = 32'd3; in_valid = 1'b1;
        @(negedge clk);
        check("rst_div_accept", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_div_busy", busy, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_div_out_valid", out_valid, 1'b0);
        check("rst_div_in_ready", in_ready, 1'b1);
        check("rst_div_busy_clr", busy, 1'b0);

        // Without the M extension, funct7 = 01 is illegal.
        @(posedge clk); #1;
        operation = 3'd0; metadata = 7'h01; lhs = 32'd3; rhs = 32'd4; nom_valid = 1'b1;
        @(negedge clk);
        check("nom_in_ready", nom_in_ready, 1'b1);
        @(posedge clk); #1;
        nom_valid = 1'b0;
        @(negedge clk);
        check("nom_out_valid", nom_out_valid, 1'b1);
        check("nom_illegal", nom_illegal, 1'b1);
        check("nom_result", nom_result, 32'd0);
        check("nom_busy", nom_busy, 1'b0);

        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
        $fatal(1);
    end
endmodule
